// File: rtl/inst_cache_pkg.sv
// Shared types and address-geometry helpers for the instruction cache.
// Imported by the cache top and its storage array.
package ic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FILL
  } ic_state_e;

  function automatic int offset_bits(input int line_beats);
    return $clog2(line_beats) + 3;
  endfunction

  function automatic int index_bits(input int num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int tag_bits(
    input int width,
    input int num_lines,
    input int line_beats
  );
    return width - offset_bits(line_beats)
         - index_bits(num_lines);
  endfunction

endpackage

// File: rtl/inst_cache_if.sv
// Line-fill channel between the instruction cache and backing memory:
// a valid/ready request and a beat-streamed response with no backpressure.
interface inst_cache_if #(
  parameter int WIDTH = 64
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_addr;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_data;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Combinational read port, beat-granular write port, clear-all.
module inst_cache_array
  import ic_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_LINES  = 16,
  parameter int LINE_BEATS = 4,
  localparam int IB = index_bits(NUM_LINES),
  localparam int TB = tag_bits(WIDTH, NUM_LINES, LINE_BEATS),
  localparam int BB = $clog2(LINE_BEATS)
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [IB-1:0]                    rd_idx_i,
  output logic                             rd_valid_o,
  output logic [TB-1:0]                    rd_tag_o,
  output logic [LINE_BEATS-1:0][WIDTH-1:0] rd_line_o,
  input  logic                             wr_beat_en_i,
  input  logic [IB-1:0]                    wr_idx_i,
  input  logic [BB-1:0]                    wr_beat_i,
  input  logic [WIDTH-1:0]                 wr_data_i,
  input  logic                             wr_tag_en_i,
  input  logic [TB-1:0]                    wr_tag_i,
  input  logic                             set_valid_i,
  input  logic                             clr_all_i
);

  logic [NUM_LINES-1:0]            valid_q;
  logic [TB-1:0]                   tag_q  [NUM_LINES];
  logic [LINE_BEATS-1:0][WIDTH-1:0] data_q [NUM_LINES];

  // Clear-all wins over a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_tag_en_i) begin
      tag_q[wr_idx_i] <= wr_tag_i;
    end
    if (wr_beat_en_i) begin
      data_q[wr_idx_i][wr_beat_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: zero-latency hits,
// whole-line refill over a valid/ready request and beat stream.
module inst_cache
  import ic_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int NUM_LINES  = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic             p_clk,
  input  logic             p_rst_l,
  input  logic [WIDTH-1:0] p_INST_MemAddress,
  input  logic             p_INST_MemRead,
  output logic [31:0]      p_INST_MemDataIn,
  output logic             p_INST_MemWait,
  input  logic             p_IC_Invalidate,
  output logic             p_MEM_ReqValid,
  input  logic             p_MEM_ReqReady,
  output logic [WIDTH-1:0] p_MEM_ReqAddr,
  input  logic             p_MEM_RspValid,
  input  logic [WIDTH-1:0] p_MEM_RspData,
  output logic [31:0]      p_IC_MissCount
);

  localparam int OFF = offset_bits(LINE_BEATS);
  localparam int IB  = index_bits(NUM_LINES);
  localparam int TB  = tag_bits(WIDTH, NUM_LINES, LINE_BEATS);
  localparam int BB  = $clog2(LINE_BEATS);
  localparam logic [BB-1:0] LAST = BB'(LINE_BEATS - 1);

  ic_state_e        state_q;
  logic             req_valid_q;
  logic [WIDTH-1:0] req_addr_q;
  logic [BB-1:0]    beat_cnt_q;
  logic             drop_q;
  logic [31:0]      miss_cnt_q;

  logic [IB-1:0] a_idx;
  logic [TB-1:0] a_tag;
  logic [BB-1:0] a_beat;
  logic          a_word;
  logic          unused_addr;

  assign a_idx  = p_INST_MemAddress[OFF +: IB];
  assign a_tag  = p_INST_MemAddress[WIDTH-1 -: TB];
  assign a_beat = p_INST_MemAddress[3 +: BB];
  assign a_word = p_INST_MemAddress[2];
  assign unused_addr = ^p_INST_MemAddress[1:0];

  logic                             rd_valid;
  logic [TB-1:0]                    rd_tag;
  logic [LINE_BEATS-1:0][WIDTH-1:0] rd_line;
  logic [WIDTH-1:0]                 sel_beat;
  logic [31:0]                      sel_word;
  logic                             hit;
  logic                             serve;

  assign hit      = rd_valid && (rd_tag == a_tag);
  assign sel_beat = rd_line[a_beat];
  assign sel_word = sel_beat[{a_word, 5'd0} +: 32];
  assign serve    = (state_q == IDLE) && p_INST_MemRead && hit;

  assign p_INST_MemDataIn = serve ? sel_word : 32'd0;
  assign p_INST_MemWait   = p_INST_MemRead &
                            ((state_q != IDLE) | ~hit);

  logic beat_en;
  logic last_beat;

  assign beat_en   = (state_q == FILL) && p_MEM_RspValid;
  assign last_beat = beat_en && (beat_cnt_q == LAST);

  inst_cache_array #(
    .WIDTH      (WIDTH),
    .NUM_LINES  (NUM_LINES),
    .LINE_BEATS (LINE_BEATS)
  ) u_array (
    .clk_i        (p_clk),
    .rst_ni       (p_rst_l),
    .rd_idx_i     (a_idx),
    .rd_valid_o   (rd_valid),
    .rd_tag_o     (rd_tag),
    .rd_line_o    (rd_line),
    .wr_beat_en_i (beat_en),
    .wr_idx_i     (req_addr_q[OFF +: IB]),
    .wr_beat_i    (beat_cnt_q),
    .wr_data_i    (p_MEM_RspData),
    .wr_tag_en_i  (last_beat),
    .wr_tag_i     (req_addr_q[WIDTH-1 -: TB]),
    .set_valid_i  (last_beat && !drop_q),
    .clr_all_i    (p_IC_Invalidate)
  );

  always_ff @(posedge p_clk or negedge p_rst_l) begin
    if (!p_rst_l) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      beat_cnt_q  <= '0;
      drop_q      <= 1'b0;
      miss_cnt_q  <= '0;
    end else begin
      if (p_IC_Invalidate && state_q != IDLE) begin
        drop_q <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (p_INST_MemRead && !hit) begin
            req_addr_q  <= {p_INST_MemAddress[WIDTH-1:OFF],
                            {OFF{1'b0}}};
            req_valid_q <= 1'b1;
            miss_cnt_q  <= miss_cnt_q + 32'd1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (p_MEM_ReqReady) begin
            req_valid_q <= 1'b0;
            beat_cnt_q  <= '0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          if (beat_en) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
          // Leaving FILL always forgets a pending drop.
          if (last_beat) begin
            drop_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign p_MEM_ReqValid = req_valid_q;
  assign p_MEM_ReqAddr  = req_addr_q;
  assign p_IC_MissCount = miss_cnt_q;

endmodule

// File: tb/tb_inst_cache.sv
// Scenario bench for inst_cache: a cycle-stepped memory responder plus
// a queue of expected fetch words popped when the core is released.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        rst_l;
  logic [63:0] addr;
  logic        read;
  logic        inv;
  logic [31:0] data;
  logic        wt;
  logic [31:0] miss;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];

  inst_cache_if #(.WIDTH(64)) mem ();

  inst_cache dut (
    .p_clk             (clk),
    .p_rst_l           (rst_l),
    .p_INST_MemAddress (addr),
    .p_INST_MemRead    (read),
    .p_INST_MemDataIn  (data),
    .p_INST_MemWait    (wt),
    .p_IC_Invalidate   (inv),
    .p_MEM_ReqValid    (mem.req_valid),
    .p_MEM_ReqReady    (mem.req_ready),
    .p_MEM_ReqAddr     (mem.req_addr),
    .p_MEM_RspValid    (mem.rsp_valid),
    .p_MEM_RspData     (mem.rsp_data),
    .p_IC_MissCount    (miss)
  );

  always #5 clk = ~clk;

  // Line 0x1000 holds k*0x11111111 in word k; elsewhere a fixed hash.
  function automatic logic [31:0] word_val(input logic [63:0] a);
    logic [31:0] k;
    if (a[63:5] == 59'h80) begin
      k = 32'(a[4:2]);
      return k * 32'h1111_1111;
    end
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [63:0] beat_val(input logic [63:0] a);
    return {word_val(a + 64'd4), word_val(a)};
  endfunction

  task automatic idle_inputs();
    mem.req_ready = 1'b0;
    mem.rsp_valid = 1'b0;
    mem.rsp_data  = '0;
    inv           = 1'b0;
  endtask

  task automatic fetch(
    input logic [63:0] a,
    input int          r,
    input int          inv_beat,
    input int          exp_wait,
    input int          exp_reqs,
    input logic [31:0] exp_miss,
    input string       name
  );
    int waits = 0;
    int reqs  = 0;
    int rc    = 0;
    int fill  = -1;
    int fills = 0;
    bit done  = 0;
    logic [63:0] la = '0;
    logic [63:0] exp_la;
    logic [31:0] exp_d;
    exp_la = {a[63:5], 5'b0};
    sb.push_back(word_val(a));
    for (int c = 0; c < 200 && !done; c++) begin
      @(posedge clk);
      #1;
      read = 1'b1;
      addr = a;
      idle_inputs();
      if (fill >= 0) begin
        mem.rsp_valid = 1'b1;
        mem.rsp_data  = beat_val(la + 64'(fill * 8));
        if (fills == 0 && fill == inv_beat) inv = 1'b1;
        fill++;
        if (fill == 4) begin
          fill = -1;
          fills++;
        end
      end else if (mem.req_valid) begin
        if (rc == 0) begin
          reqs++;
          la = mem.req_addr;
          checks++;
          if (la !== exp_la) begin
            errors++;
            $display("FAIL %s req_addr: got %h want %h",
                     name, la, exp_la);
          end
        end
        rc++;
        if (rc == r) begin
          mem.req_ready = 1'b1;
          rc   = 0;
          fill = 0;
        end
      end
      #1;
      if (!wt) begin
        exp_d = sb.pop_front();
        checks++;
        if (data !== exp_d) begin
          errors++;
          $display("FAIL %s data: got %h want %h",
                   name, data, exp_d);
        end
        done = 1;
      end else begin
        waits++;
      end
    end
    idle_inputs();
    checks++;
    if (!done) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL %s timeout: got wait stuck want release", name);
    end
    checks++;
    if (waits != exp_wait) begin
      errors++;
      $display("FAIL %s wait_cycles: got %0d want %0d",
               name, waits, exp_wait);
    end
    checks++;
    if (reqs != exp_reqs) begin
      errors++;
      $display("FAIL %s requests: got %0d want %0d",
               name, reqs, exp_reqs);
    end
    checks++;
    if (miss !== exp_miss) begin
      errors++;
      $display("FAIL %s miss_count: got %0d want %0d",
               name, miss, exp_miss);
    end
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    read  = 1'b0;
    addr  = '0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (mem.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset req_valid: got %b want 0", mem.req_valid);
    end
    checks++;
    if (mem.req_addr !== 64'd0) begin
      errors++;
      $display("FAIL reset req_addr: got %h want 0", mem.req_addr);
    end
    checks++;
    if (miss !== 32'd0) begin
      errors++;
      $display("FAIL reset miss_count: got %0d want 0", miss);
    end
    checks++;
    if (data !== 32'd0 || wt !== 1'b0) begin
      errors++;
      $display("FAIL reset core: got data %h wait %b want 0/0",
               data, wt);
    end
    @(negedge clk);
    rst_l = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(64'h1004, 2, -1, 7, 1, 32'd1, "cold_miss");
  endtask

  task automatic test_hit();
    fetch(64'h1018, 1, -1, 0, 0, 32'd1, "hit_18");
    fetch(64'h101C, 1, -1, 0, 0, 32'd1, "hit_1c");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      fetch(64'h1000 + 64'(i * 4), 1, -1, 0, 0, 32'd1, "b2b");
    end
  endtask

  task automatic test_conflict();
    fetch(64'h1204, 1, -1, 6, 1, 32'd2, "conflict");
    fetch(64'h1004, 1, -1, 6, 1, 32'd3, "conflict_back");
  endtask

  task automatic test_inv_mid_fill();
    fetch(64'h1404, 2, 1, 14, 2, 32'd5, "inv_fill");
  endtask

  task automatic test_inv_idle();
    @(posedge clk);
    #1;
    read = 1'b0;
    inv  = 1'b1;
    @(posedge clk);
    #1;
    inv = 1'b0;
    fetch(64'h1404, 1, -1, 6, 1, 32'd6, "inv_idle");
  endtask

  task automatic test_reset_mid_req();
    bit seen = 0;
    @(posedge clk);
    #1;
    read = 1'b1;
    addr = 64'h2000;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (mem.req_valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_req req_seen: got 0 want 1");
    end
    #2;
    rst_l = 1'b0;
    #1;
    checks++;
    if (mem.req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req req_valid: got %b want 0",
               mem.req_valid);
    end
    checks++;
    if (miss !== 32'd0) begin
      errors++;
      $display("FAIL rst_req miss_count: got %0d want 0", miss);
    end
    read = 1'b0;
    @(negedge clk);
    rst_l = 1'b1;
    fetch(64'h1004, 2, -1, 7, 1, 32'd1, "rst_refill");
  endtask

  task automatic test_stray_beat();
    @(posedge clk);
    #1;
    read          = 1'b0;
    mem.rsp_valid = 1'b1;
    mem.rsp_data  = 64'hDEAD;
    @(posedge clk);
    #1;
    idle_inputs();
    fetch(64'h1000, 1, -1, 0, 0, 32'd1, "stray_w0");
    fetch(64'h1004, 1, -1, 0, 0, 32'd1, "stray_w1");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_inv_mid_fill();
    test_inv_idle();
    test_reset_mid_req();
    test_stray_beat();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache between the MIPS64 core's instruction fetch port and a variable-latency backing memory. Serves hits combinationally in the fetch cycle and stalls the core through `p_INST_MemWait` on a miss. On a miss it fills one whole line through a valid/ready request channel and a beat-streamed response channel.

## Interface
- `WIDTH`, 64: address and memory beat width.
- `NUM_LINES`, 16: number of lines. Must be a power of 2, ≥2.
- `LINE_BEATS`, 4: 64-bit beats per line. Must be a power of 2, ≥2.
- `p_clk` input 1: single clock, rising edge.
- `p_rst_l` input 1: reset, asynchronous assert, active-low.
- `p_INST_MemAddress` input WIDTH: fetch byte address from the core.
- `p_INST_MemRead` input 1: fetch request from the core.
- `p_INST_MemDataIn` output 32: fetched instruction to the core.
- `p_INST_MemWait` output 1: stall to the core.
- `p_IC_Invalidate` input 1: single-cycle pulse that invalidates all lines.
- `p_MEM_ReqValid` output 1: line-fill request valid.
- `p_MEM_ReqReady` input 1: backing memory accepts the request.
- `p_MEM_ReqAddr` output WIDTH: line-aligned fill address.
- `p_MEM_RspValid` input 1: response beat valid. There is no backpressure on this channel.
- `p_MEM_RspData` input WIDTH: response beat. Beats arrive in ascending address order.
- `p_IC_MissCount` output 32: count of misses since reset. Wraps modulo 2^32.

## Operation
- **Address split** (defaults): bits [1:0] are ignored; bit [2] selects the word within a beat (0 → beat[31:0], 1 → beat[63:32]); bits [4:3] select the beat; bits [8:5] are the index; bits [63:9] are the tag. In general, the index is log2(NUM_LINES) bits above the line offset of log2(LINE_BEATS)+3 bits.
- **Storage:** one valid bit, one tag, and LINE_BEATS×64 data bits per line.
- **Hit:** `valid[idx]` is set and `tag[idx]` equals the address tag.
- **States:** IDLE, REQ, FILL.
- **IDLE**
  - Read and hit: `p_INST_MemDataIn` = selected word and `p_INST_MemWait` = 0, both in the same cycle.
  - Read and miss: `p_INST_MemWait` = 1. Latch the line address, increment `p_IC_MissCount`, and go to REQ.
- **REQ**
  - `p_MEM_ReqValid` = 1 and `p_MEM_ReqAddr` = the latched line address; both stay stable until `p_MEM_ReqReady`.
  - On ready, go to FILL and clear the beat counter.
- **FILL**
  - Each `p_MEM_RspValid` writes `p_MEM_RspData` into the beat slot given by the beat counter, then increments the counter.
  - On the last beat: write the tag and set the valid bit (unless the drop flag is set), then go to IDLE.
- **Wait rule:** `p_INST_MemWait` = `p_INST_MemRead` & (state≠IDLE | ~hit).
- **Data rule:** `p_INST_MemDataIn` = 0 whenever the core is not being served by a hit in IDLE.
- **Invalidate:** clears all valid bits next edge. If it arrives in REQ or FILL, it sets the drop flag. The in-flight fill still completes, but its valid bit is not set. The drop flag clears on return to IDLE.
- **Core drops read or changes address mid-miss:** the fill completes regardless. The next lookup uses the current address.
- **Response beats outside FILL:** ignored.
- **Reset mid-fill:** return to IDLE and clear all valid bits. The abandoned request is the memory side's responsibility to drain.

## Timing
- **Reset values:** state IDLE; all valid bits 0; `p_MEM_ReqValid` 0; `p_MEM_ReqAddr` 0; `p_IC_MissCount` 0; `p_INST_MemDataIn` 0; `p_INST_MemWait` 0 (it follows the wait rule after reset).
- **Hit latency:** 0 cycles (combinational from address).
- **Miss:**
  - Miss detected in cycle 0, so REQ starts in cycle 1.
  - The request accept takes r cycles, where r ≥ 1 is the number of REQ cycles up to and including the one with ready.
  - The B beats then arrive over f ≥ LINE_BEATS cycles.
  - IDLE follows the last beat by 1 cycle, and the hit is served that cycle, so minimum wait is 1 + 1 + 4 = 6 cycles with defaults.
- **Miss counter:** increments on the IDLE→REQ edge only. It does not increment again for a re-missed dropped line beyond the real re-miss.
- **Simultaneous last beat and invalidate:** the line is not made valid.

## Structure
- **Package `ic_pkg`:**
  - Contains the state enum (IDLE/REQ/FILL).
  - Contains functions deriving OFFSET_BITS, INDEX_BITS and TAG_BITS from the parameters.
- **Sub-module `inst_cache_array`:**
  - Holds the valid/tag/data storage.
  - Provides a combinational read port (index → valid, tag, line).
  - Provides a write port (beat write, tag+valid set, clear-all).
  - The FSM, address split and counter live in `inst_cache`.

## Test plan
- **Cold miss:**
  - Stimulus: after reset, read 0x1004. Memory sets ready on the 2nd REQ cycle and returns beats 0x11111111_00000000, 0x33333333_22222222, 0x55555555_44444444, 0x77777777_66666666 on consecutive cycles.
  - Required response: wait holds for 7 cycles, then data = 0x11111111 with wait = 0, and MissCount = 1.
- **Hit after fill:**
  - Stimulus: reads of 0x1018 and 0x101C.
  - Required response: 0x66666666 and 0x77777777 with zero wait, and no new request.
- **Conflict:**
  - Stimulus: read 0x1204 (same index, different tag).
  - Required response: a miss with ReqAddr = 0x1200. Afterwards 0x1004 misses again, and MissCount = 3.
- **Invalidate mid-fill:**
  - Stimulus: pulse `p_IC_Invalidate` during the 2nd FILL beat.
  - Required response: the fill completes, the next read of the same address misses again, and ReqValid re-asserts.
- **Reset mid-REQ:**
  - Stimulus: drop `p_rst_l` while ReqValid = 1.
  - Required response: ReqValid = 0 immediately (asynchronously), and a prior hit address now misses.
- **Stray beat:**
  - Stimulus: RspValid in IDLE with data 0xDEAD.
  - Required response: no array change, and a following hit returns the original data.
